// File: rtl/block_buffer_if.sv
// Loader, memory-write and MAC-sequencer signals of the ping-pong block buffer controller.
interface block_buffer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [5:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fsm_start;
  logic              fsm_ready;
  logic              rd_bank;
  logic              block_done;
  logic [15:0]       blocks_done_cnt;
  logic              err_spurious;

  modport master (
    output in_valid, in_data, fsm_ready,
    input  in_ready, wr_en, wr_bank, wr_addr, wr_data, fsm_start,
           rd_bank, block_done, blocks_done_cnt, err_spurious
  );

  modport slave (
    input  in_valid, in_data, fsm_ready,
    output in_ready, wr_en, wr_bank, wr_addr, wr_data, fsm_start,
           rd_bank, block_done, blocks_done_cnt, err_spurious
  );
endinterface

// File: rtl/block_buffer_ctrl.sv
// Two-bank ping-pong controller: fills 64-sample blocks and hands full banks to the MAC sequencer.
//   state  | meaning
//   C_IDLE | no block computing; start the read bank as soon as it is FULL
//   C_RUN  | block computing; count fsm_ready rising edges up to N_COEF
module block_buffer_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_COEF = 64
) (
  input logic          clock,
  input logic          reset,
  block_buffer_if.slave bus
);
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_COMPUTING} bank_t;
  typedef enum logic {C_IDLE, C_RUN} cstate_t;

  localparam logic [6:0] LAST_COEF = 7'(N_COEF - 1);

  bank_t             bank_q [2];
  bank_t             bank_d [2];
  cstate_t           c_q, c_d;
  logic              wsel_q, wsel_d;
  logic              rd_q, rd_d;
  logic [5:0]        fill_q, fill_d;
  logic [6:0]        rcnt_q, rcnt_d;
  logic              ready_q;
  logic              err_q, err_d;
  logic [15:0]       dcnt_q, dcnt_d;
  logic              start_q, start_d;
  logic              bdone_q, bdone_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_bank_q, wr_bank_d;
  logic [5:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              in_ready_int;
  logic              accept;
  logic              rise;

  assign in_ready_int = (bank_q[wsel_q] == B_EMPTY) || (bank_q[wsel_q] == B_FILLING);
  assign accept       = bus.in_valid && in_ready_int;
  assign rise         = bus.fsm_ready && !ready_q;

  always_comb begin
    bank_d    = bank_q;
    c_d       = c_q;
    wsel_d    = wsel_q;
    rd_d      = rd_q;
    fill_d    = fill_q;
    rcnt_d    = rcnt_q;
    err_d     = err_q;
    dcnt_d    = dcnt_q;
    start_d   = 1'b0;
    bdone_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Fill and compute never touch the same bank in one cycle: their bank states are disjoint.
    if (accept) begin
      wr_en_d   = 1'b1;
      wr_bank_d = wsel_q;
      wr_addr_d = fill_q;
      wr_data_d = bus.in_data;
      if (fill_q == 6'd63) begin
        bank_d[wsel_q] = B_FULL;
        fill_d         = 6'd0;
        wsel_d         = !wsel_q;
      end else begin
        bank_d[wsel_q] = B_FILLING;
        fill_d         = fill_q + 6'd1;
      end
    end

    if (c_q == C_IDLE) begin
      if (rise) err_d = 1'b1;
      if (bank_q[rd_q] == B_FULL) begin
        start_d      = 1'b1;
        bank_d[rd_q] = B_COMPUTING;
        rcnt_d       = 7'd0;
        c_d          = C_RUN;
      end
    end else if (rise) begin
      if (rcnt_q == LAST_COEF) begin
        bank_d[rd_q] = B_EMPTY;
        rd_d         = !rd_q;
        bdone_d      = 1'b1;
        dcnt_d       = dcnt_q + 16'd1;
        c_d          = C_IDLE;
      end else begin
        rcnt_d = rcnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      c_q       <= C_IDLE;
      wsel_q    <= 1'b0;
      rd_q      <= 1'b0;
      fill_q    <= 6'd0;
      rcnt_q    <= 7'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      dcnt_q    <= 16'd0;
      start_q   <= 1'b0;
      bdone_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= 6'd0;
      wr_data_q <= '0;
    end else begin
      bank_q    <= bank_d;
      c_q       <= c_d;
      wsel_q    <= wsel_d;
      rd_q      <= rd_d;
      fill_q    <= fill_d;
      rcnt_q    <= rcnt_d;
      ready_q   <= bus.fsm_ready;
      err_q     <= err_d;
      dcnt_q    <= dcnt_d;
      start_q   <= start_d;
      bdone_q   <= bdone_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready        = in_ready_int;
  assign bus.wr_en           = wr_en_q;
  assign bus.wr_bank         = wr_bank_q;
  assign bus.wr_addr         = wr_addr_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.fsm_start       = start_q;
  assign bus.rd_bank         = rd_q;
  assign bus.block_done      = bdone_q;
  assign bus.blocks_done_cnt = dcnt_q;
  assign bus.err_spurious    = err_q;
endmodule

// File: tb/tb_block_buffer_ctrl.sv
// Scoreboard bench for block_buffer_ctrl: block-level reference model feeds queues, a negedge monitor checks.
module tb_block_buffer_ctrl;
  localparam int DW = 8;
  localparam int NC = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_buffer_if #(.DATA_W(DW)) bus ();
  block_buffer_ctrl #(.DATA_W(DW), .N_COEF(NC)) dut (.clock(clk), .reset(rst), .bus(bus));

  typedef struct {int cyc; bit bank; int addr; int data;} wr_t;
  typedef struct {int cyc; bit is_done; bit bank; int cnt;} ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];
  wr_t we;
  ev_t ee;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int wr_seen = 0, done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write strobe or an event pulse.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_seen++;
      chk("wr_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        chk("wr_cycle", cyc, we.cyc);
        chk("wr_bank", bus.wr_bank, we.bank);
        chk("wr_addr", bus.wr_addr, we.addr);
        chk("wr_data", bus.wr_data, we.data);
      end
    end
    if (bus.fsm_start === 1'b1 || bus.block_done === 1'b1) begin
      if (bus.block_done === 1'b1) done_seen++;
      chk("ev_expected", ev_q.size() != 0, 1);
      if (ev_q.size() != 0) begin
        ee = ev_q.pop_front();
        chk("ev_cycle", cyc, ee.cyc);
        chk("ev_block_done", bus.block_done, ee.is_done);
        chk("ev_fsm_start", bus.fsm_start, !ee.is_done);
        if (ee.is_done) begin
          chk("done_rd_bank", bus.rd_bank, !ee.bank);
          chk("done_cnt", bus.blocks_done_cnt, ee.cnt);
        end else begin
          chk("start_rd_bank", bus.rd_bank, ee.bank);
        end
      end
    end
  end

  // Reference model: per-bank sample counts plus a computing flag.
  int  m_fill[2];
  bit  m_comp[2];
  bit  m_wsel, m_rd, m_run, m_err, m_prev;
  int  m_rcnt, m_ndone;
  bit  armed = 0;
  bit  last_acc;
  int  next_data;

  task automatic model_reset();
    m_fill[0] = 0; m_fill[1] = 0; m_comp[0] = 0; m_comp[1] = 0;
    m_wsel = 0; m_rd = 0; m_run = 0; m_err = 0; m_prev = 0; m_rcnt = 0; m_ndone = 0;
  endtask

  // Called #1 after a rising edge: checks the current state, drives this cycle, predicts the next edge.
  task automatic step(input bit v, input int d, input bit fr, input bit rs);
    bit rdy, rise;
    rdy = !m_comp[m_wsel] && (m_fill[m_wsel] < 64);
    if (armed) begin
      chk("in_ready", bus.in_ready, rdy);
      chk("rd_bank", bus.rd_bank, m_rd);
      chk("err_spurious", bus.err_spurious, m_err);
      chk("blocks_done_cnt", bus.blocks_done_cnt, m_ndone);
    end
    bus.in_valid  = v;
    bus.in_data   = DW'(d);
    bus.fsm_ready = fr;
    rst           = rs;
    last_acc      = 0;
    if (rs) begin
      model_reset();
    end else begin
      rise = fr && !m_prev;
      if (!m_run) begin
        if (rise) m_err = 1;
        if (m_fill[m_rd] == 64 && !m_comp[m_rd]) begin
          ev_q.push_back('{cyc: cyc + 1, is_done: 0, bank: m_rd, cnt: 0});
          m_run = 1; m_comp[m_rd] = 1; m_rcnt = 0;
        end
      end else if (rise) begin
        m_rcnt++;
        if (m_rcnt == NC) begin
          m_ndone = (m_ndone + 1) % 65536;
          ev_q.push_back('{cyc: cyc + 1, is_done: 1, bank: m_rd, cnt: m_ndone});
          m_fill[m_rd] = 0; m_comp[m_rd] = 0; m_rd = !m_rd; m_run = 0;
        end
      end
      if (v && rdy) begin
        wr_q.push_back('{cyc: cyc + 1, bank: m_wsel, addr: m_fill[m_wsel], data: d % 256});
        m_fill[m_wsel]++;
        if (m_fill[m_wsel] == 64) m_wsel = !m_wsel;
        last_acc = 1;
      end
      m_prev = fr;
    end
    @(posedge clk);
    #1;
    if (rs) armed = 1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_bank"}, bus.wr_bank, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_fsm_start"}, bus.fsm_start, 0);
    chk({tag, "_block_done"}, bus.block_done, 0);
    chk({tag, "_rd_bank"}, bus.rd_bank, 0);
    chk({tag, "_cnt"}, bus.blocks_done_cnt, 0);
    chk({tag, "_err"}, bus.err_spurious, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic load(input int n, input bit fr);
    int got = 0;
    for (int i = 0; i < 4 * n + 200 && got < n; i++) begin
      step(1, next_data, fr, 0);
      if (last_acc) begin got++; next_data = $urandom_range(0, 255); end
    end
    chk("load_count", got, n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int pulses, saved_done, b2b_acc;
    bit fr;
    bus.in_valid = 0; bus.in_data = 0; bus.fsm_ready = 0; rst = 1;
    next_data = $urandom_range(0, 255);
    @(posedge clk); #1;

    do_reset();
    check_reset_outputs("reset");

    // 64 samples 0..63 into bank 0, then start two cycles after the last accept
    for (int i = 0; i < 64; i++) step(1, i, 0, 0);
    idle(3);
    chk("p1_writes", wr_seen, 64);
    chk("p1_rd_bank", bus.rd_bank, 0);

    // keep loading with no fsm_ready: bank 1 fills, then the loader stalls
    for (int i = 0; i < 300; i++) begin
      step(1, next_data, 0, 0);
      if (last_acc) next_data = $urandom_range(0, 255);
    end
    chk("p2_writes", wr_seen, 128);
    chk("p2_stalled", bus.in_ready, 0);

    // 64 two-cycle fsm_ready pulses while the loader keeps offering
    saved_done = done_seen;
    for (int p = 0; p < NC; p++) begin
      for (int k = 0; k < 4; k++) begin
        step(1, next_data, k < 2, 0);
        if (last_acc) next_data = $urandom_range(0, 255);
      end
    end
    idle(3);
    chk("p3_done_pulses", done_seen - saved_done, 1);
    chk("p3_rd_bank", bus.rd_bank, 1);
    chk("p3_cnt", bus.blocks_done_cnt, 1);

    // spurious fsm_ready with nothing loaded
    do_reset();
    step(0, 0, 1, 0); step(0, 0, 1, 0); idle(4);
    chk("p4_err_sticky", bus.err_spurious, 1);
    chk("p4_in_ready", bus.in_ready, 1);

    // reset mid-fill and mid-compute
    do_reset();
    saved_done = done_seen;
    load(30, 0);
    do_reset();
    check_reset_outputs("mid_fill");
    load(64, 0);
    idle(3);
    pulses = 0;
    for (int i = 0; i < 20; i++) step(0, 0, i % 2 == 0, 0);
    do_reset();
    check_reset_outputs("mid_compute");
    step(1, 8'hA5, 0, 0);
    idle(2);
    chk("p5_no_done", done_seen - saved_done, 0);

    // 64 back-to-back blocks
    do_reset();
    wr_seen = 0; done_seen = 0; b2b_acc = 0; fr = 0;
    for (int i = 0; i < 20000 && done_seen < 64; i++) begin
      fr = !fr;
      step(b2b_acc < 64 * 64, next_data, fr, 0);
      if (last_acc) begin b2b_acc++; next_data = $urandom_range(0, 255); end
    end
    idle(3);
    chk("p6_writes", wr_seen, 4096);
    chk("p6_done_pulses", done_seen, 64);
    chk("p6_cnt", bus.blocks_done_cnt, 64);

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, next_data, 1'($urandom_range(0, 1)), 0);
        if (last_acc) next_data = $urandom_range(0, 255);
      end
    end
    idle(6);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("ev_queue_drained", ev_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
